// File: rtl/mux21_arbiter.sv
// Two-requester round-robin arbiter sharing one 2:1 mux output path.
// Grant and mux select are registered; out_data, out_valid and ack are
// combinational from the registered grant and the live request/ready inputs.
// A requester keeps the grant for at most MAX_HOLD accepted beats while the
// other requester waits. With no competitor it keeps the grant indefinitely.
module mux21_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [1:0]            req,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  sel,
    output logic [1:0]            grant,
    output logic [1:0]            ack
);

    // Beat counter is at least one bit wide so MAX_HOLD=1 still elaborates.
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arbStateT;

    arbStateT         state;
    arbStateT         nextState;
    arbStateT         otherState;
    logic [CNT_W-1:0] beatCnt;
    logic [CNT_W-1:0] nextBeatCnt;
    logic             last;       // index of the requester that held the grant most recently
    logic             nextLast;
    logic             servedIdx;  // requester index owning the grant (meaningful in G0/G1)
    logic             ownReq;     // granted requester is still requesting
    logic             otherReq;   // the non-granted requester is waiting
    logic             xfer;

    // Decode which requester the current state serves and what the other one wants.
    always_comb begin
        servedIdx  = (state == G1);
        ownReq     = 1'b0;
        otherReq   = 1'b0;
        otherState = IDLE;
        case (state)
            G0: begin
                ownReq     = req[0];
                otherReq   = req[1];
                otherState = G1;
            end
            G1: begin
                ownReq     = req[1];
                otherReq   = req[0];
                otherState = G0;
            end
            default: begin
                ownReq     = 1'b0;
                otherReq   = 1'b0;
                otherState = IDLE;
            end
        endcase
    end

    // State register: FSM state, tenure counter, round-robin pointer, registered grant/select.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            beatCnt <= '0;
            last    <= 1'b1;
            grant   <= 2'b00;
            sel     <= 1'b0;
        end else begin
            state   <= nextState;
            beatCnt <= nextBeatCnt;
            last    <= nextLast;
            grant   <= {nextState == G1, nextState == G0};
            sel     <= (nextState == G1);
        end
    end

    // Next-state logic: round-robin tie break from IDLE, tenure limit and release in G0/G1.
    always_comb begin
        nextState   = state;
        nextBeatCnt = beatCnt;
        nextLast    = last;
        case (state)
            IDLE: begin
                nextBeatCnt = '0;
                case (req)
                    2'b01:   nextState = G0;
                    2'b10:   nextState = G1;
                    2'b11:   nextState = last ? G0 : G1;
                    default: nextState = IDLE;
                endcase
            end
            G0, G1: begin
                if (!ownReq) begin
                    // Granted requester went away: hand over directly or fall idle.
                    nextLast    = servedIdx;
                    nextBeatCnt = '0;
                    nextState   = otherReq ? otherState : IDLE;
                end else if (xfer) begin
                    if (beatCnt == HOLD_LAST) begin
                        // Tenure used up; only yield if someone is actually waiting.
                        nextBeatCnt = '0;
                        if (otherReq) begin
                            nextLast  = servedIdx;
                            nextState = otherState;
                        end
                    end else begin
                        nextBeatCnt = beatCnt + CNT_W'(1);
                    end
                end
                // Stalled beat (out_ready low): everything holds.
            end
            default: begin
                nextState   = IDLE;
                nextBeatCnt = '0;
            end
        endcase
    end

    // Output logic: valid follows the granted request; reset suppresses any in-flight beat.
    always_comb begin
        out_valid = ownReq & ~Reset;
        xfer      = out_valid & out_ready;
        ack       = 2'b00;
        if (xfer) begin
            ack[servedIdx] = 1'b1;
        end
    end

    // Shared mux path, zero latency from the data inputs.
    assign out_data = sel ? in1 : in0;

endmodule

// File: tb/tb_mux21_arbiter.sv
// Self-checking bench for mux21_arbiter: scenario tasks with a scoreboard of
// expected accepted beats (requester index + word), popped on each accept.
module tb_mux21_arbiter;

    logic       CLK;
    logic       Reset;
    logic [1:0] req;
    logic [7:0] in0;
    logic [7:0] in1;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       sel;
    logic [1:0] grant;
    logic [1:0] ack;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } beatT;

    beatT expQ[$];
    int   passCnt  = 0;
    int   totalCnt = 0;

    mux21_arbiter #(.DATA_WIDTH(8), .MAX_HOLD(4)) dut (
        .CLK(CLK), .Reset(Reset), .req(req), .in0(in0), .in1(in1),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .grant(grant), .ack(ack)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyReset();
        Reset = 1'b1; req = 2'b00; out_ready = 1'b0;
        stepCycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1; req = 2'b11; in0 = 8'h00; in1 = 8'h00; out_ready = 1'b1;
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            totalCnt++; if (grant !== 2'b00) $display("FAIL reset_grant cyc%0d got %b want 00", i, grant); else passCnt++;
            totalCnt++; if (sel !== 1'b0) $display("FAIL reset_sel cyc%0d got %b want 0", i, sel); else passCnt++;
            totalCnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got %b want 0", i, out_valid); else passCnt++;
            totalCnt++; if (ack !== 2'b00) $display("FAIL reset_ack cyc%0d got %b want 00", i, ack); else passCnt++;
            stepCycle();
        end
    endtask

    task automatic test_no_contention();
        beatT e;
        applyReset();
        req = 2'b01; in0 = 8'hA5; in1 = 8'h5A; out_ready = 1'b1;
        @(negedge CLK);
        totalCnt++; if (grant !== 2'b00) $display("FAIL nc_latency_grant got %b want 00", grant); else passCnt++;
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL nc_latency_valid got %b want 0", out_valid); else passCnt++;
        stepCycle();
        for (int i = 0; i < 6; i++) expQ.push_back('{port: 1'b0, data: 8'hA5});
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            totalCnt++; if (grant !== 2'b01) $display("FAIL nc_grant beat%0d got %b want 01", i, grant); else passCnt++;
            totalCnt++; if (sel !== 1'b0) $display("FAIL nc_sel beat%0d got %b want 0", i, sel); else passCnt++;
            totalCnt++; if (out_valid !== 1'b1) $display("FAIL nc_valid beat%0d got %b want 1", i, out_valid); else passCnt++;
            if (expQ.size() == 0) begin
                totalCnt++; $display("FAIL nc_underflow beat%0d ack %b with empty scoreboard", i, ack);
            end else begin
                e = expQ.pop_front();
                totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL nc_ack beat%0d got %b want port %0d", i, ack, e.port); else passCnt++;
                totalCnt++; if (out_data !== e.data) $display("FAIL nc_data beat%0d got %h want %h", i, out_data, e.data); else passCnt++;
            end
            stepCycle();
        end
        req = 2'b00;
        totalCnt++; if (expQ.size() != 0) $display("FAIL nc_leftover got %0d want 0", expQ.size()); else passCnt++;
        expQ.delete();
    endtask

    task automatic test_round_robin();
        beatT e;
        applyReset();
        req = 2'b11; in0 = 8'h11; in1 = 8'h22; out_ready = 1'b1;
        stepCycle();
        for (int i = 0; i < 4; i++) expQ.push_back('{port: 1'b0, data: 8'h11});
        for (int i = 0; i < 4; i++) expQ.push_back('{port: 1'b1, data: 8'h22});
        for (int i = 0; i < 2; i++) expQ.push_back('{port: 1'b0, data: 8'h11});
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (expQ.size() == 0) begin
                totalCnt++; $display("FAIL rr_underflow beat%0d ack %b with empty scoreboard", i, ack);
            end else begin
                e = expQ.pop_front();
                totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL rr_ack beat%0d got %b want port %0d", i, ack, e.port); else passCnt++;
                totalCnt++; if (sel !== e.port) $display("FAIL rr_sel beat%0d got %b want %b", i, sel, e.port); else passCnt++;
                totalCnt++; if (out_data !== e.data) $display("FAIL rr_data beat%0d got %h want %h", i, out_data, e.data); else passCnt++;
            end
            stepCycle();
        end
        req = 2'b00;
        totalCnt++; if (expQ.size() != 0) $display("FAIL rr_leftover got %0d want 0", expQ.size()); else passCnt++;
        expQ.delete();
    endtask

    task automatic test_backpressure();
        beatT e;
        applyReset();
        req = 2'b11; in0 = 8'h33; in1 = 8'h44; out_ready = 1'b1;
        stepCycle();
        // Two beats, a five-cycle stall, then two more beats before the switch.
        expQ.push_back('{port: 1'b0, data: 8'h33});
        expQ.push_back('{port: 1'b0, data: 8'h33});
        for (int i = 0; i < 9; i++) begin
            if (i == 2) out_ready = 1'b0;
            if (i == 7) out_ready = 1'b1;
            if (i == 7) begin
                expQ.push_back('{port: 1'b0, data: 8'h33});
                expQ.push_back('{port: 1'b0, data: 8'h33});
                expQ.push_back('{port: 1'b1, data: 8'h44});
            end
            @(negedge CLK);
            if (i >= 2 && i < 7) begin
                totalCnt++; if (grant !== 2'b01) $display("FAIL bp_grant stall%0d got %b want 01", i, grant); else passCnt++;
                totalCnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid stall%0d got %b want 1", i, out_valid); else passCnt++;
                totalCnt++; if (ack !== 2'b00) $display("FAIL bp_ack stall%0d got %b want 00", i, ack); else passCnt++;
            end else if (expQ.size() == 0) begin
                totalCnt++; $display("FAIL bp_underflow cyc%0d ack %b with empty scoreboard", i, ack);
            end else begin
                e = expQ.pop_front();
                totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL bp_ack cyc%0d got %b want port %0d", i, ack, e.port); else passCnt++;
                totalCnt++; if (out_data !== e.data) $display("FAIL bp_data cyc%0d got %h want %h", i, out_data, e.data); else passCnt++;
            end
            if (i == 8) begin
                // Final item (port 1) is popped one cycle later.
            end
            stepCycle();
        end
        @(negedge CLK);
        if (expQ.size() == 0) begin
            totalCnt++; $display("FAIL bp_underflow switch ack %b with empty scoreboard", ack);
        end else begin
            e = expQ.pop_front();
            totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL bp_switch_ack got %b want port %0d", ack, e.port); else passCnt++;
            totalCnt++; if (out_data !== e.data) $display("FAIL bp_switch_data got %h want %h", out_data, e.data); else passCnt++;
        end
        stepCycle();
        req = 2'b00;
        totalCnt++; if (expQ.size() != 0) $display("FAIL bp_leftover got %0d want 0", expQ.size()); else passCnt++;
        expQ.delete();
    endtask

    task automatic test_drop_to_idle();
        beatT e;
        applyReset();
        req = 2'b10; in0 = 8'h66; in1 = 8'h55; out_ready = 1'b1;
        stepCycle();
        expQ.push_back('{port: 1'b1, data: 8'h55});
        expQ.push_back('{port: 1'b1, data: 8'h55});
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            e = expQ.pop_front();
            totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL drop_ack beat%0d got %b want port %0d", i, ack, e.port); else passCnt++;
            totalCnt++; if (out_data !== e.data) $display("FAIL drop_data beat%0d got %h want %h", i, out_data, e.data); else passCnt++;
            stepCycle();
        end
        req = 2'b00;
        @(negedge CLK);
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL drop_valid got %b want 0", out_valid); else passCnt++;
        totalCnt++; if (ack !== 2'b00) $display("FAIL drop_ack_low got %b want 00", ack); else passCnt++;
        stepCycle();
        req = 2'b11;
        @(negedge CLK);
        totalCnt++; if (grant !== 2'b00) $display("FAIL drop_idle_grant got %b want 00", grant); else passCnt++;
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL drop_idle_valid got %b want 0", out_valid); else passCnt++;
        stepCycle();
        expQ.push_back('{port: 1'b0, data: 8'h66});
        @(negedge CLK);
        totalCnt++; if (grant !== 2'b01) $display("FAIL drop_regrant got %b want 01", grant); else passCnt++;
        e = expQ.pop_front();
        totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL drop_regrant_ack got %b want port %0d", ack, e.port); else passCnt++;
        totalCnt++; if (out_data !== e.data) $display("FAIL drop_regrant_data got %h want %h", out_data, e.data); else passCnt++;
        stepCycle();
        req = 2'b00;
        expQ.delete();
    endtask

    task automatic test_reset_midburst();
        beatT e;
        applyReset();
        req = 2'b10; in0 = 8'h88; in1 = 8'h77; out_ready = 1'b1;
        stepCycle();
        expQ.push_back('{port: 1'b1, data: 8'h77});
        expQ.push_back('{port: 1'b1, data: 8'h77});
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            e = expQ.pop_front();
            totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL mid_ack beat%0d got %b want port %0d", i, ack, e.port); else passCnt++;
            stepCycle();
        end
        Reset = 1'b1; req = 2'b11;
        @(negedge CLK);
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_valid); else passCnt++;
        totalCnt++; if (ack !== 2'b00) $display("FAIL mid_rst_ack got %b want 00", ack); else passCnt++;
        stepCycle();
        Reset = 1'b0;
        @(negedge CLK);
        totalCnt++; if (grant !== 2'b00) $display("FAIL mid_idle_grant got %b want 00", grant); else passCnt++;
        totalCnt++; if (sel !== 1'b0) $display("FAIL mid_idle_sel got %b want 0", sel); else passCnt++;
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL mid_idle_valid got %b want 0", out_valid); else passCnt++;
        stepCycle();
        expQ.push_back('{port: 1'b0, data: 8'h88});
        @(negedge CLK);
        totalCnt++; if (grant !== 2'b01) $display("FAIL mid_regrant got %b want 01", grant); else passCnt++;
        e = expQ.pop_front();
        totalCnt++; if (ack !== (e.port ? 2'b10 : 2'b01)) $display("FAIL mid_regrant_ack got %b want port %0d", ack, e.port); else passCnt++;
        totalCnt++; if (out_data !== e.data) $display("FAIL mid_regrant_data got %h want %h", out_data, e.data); else passCnt++;
        stepCycle();
        req = 2'b00;
        expQ.delete();
    endtask

    initial begin
        Reset = 1'b1; req = 2'b00; in0 = 8'h00; in1 = 8'h00; out_ready = 1'b0;
        test_reset();
        test_no_contention();
        test_round_robin();
        test_backpressure();
        test_drop_to_idle();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
